qoi_decoder: RTL and testbench
==============================

# qoi_decoder

Streaming QOI chunk decoder: consumes the encoded chunk byte stream (header and end marker already stripped) one byte per cycle and emits one RGBA pixel per cycle. It is the receive-side counterpart of the QOI encoder and shares its pixel model: previous pixel, 64-entry hash index and run counter. Input and output use valid/ready handshakes, so it sits between a byte FIFO or DMA source and the pixel sink (framebuffer writer or display pipe).

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  chunk byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_r, out_g, out_b, out_a  out  8 each  decoded pixel
- out_valid  out  1  pixel valid
- out_ready  in  1  pixel consumed when out_valid && out_ready
- px_count  out  32  pixels consumed (only with QOI_DECODER_PXCOUNT_EN)

## Operation
- State: prev pixel {pr,pg,pb,pa}, index[64]×32b, FSM state, arg byte counter, opcode latch, run_left[5:0].
- Reset: prev = (0,0,0,255); every index entry = 0; FSM = OP; out_valid = 0; out_r/g/b/a = 0; in_ready = 0 during the reset cycle; px_count = 0.
- Opcode decode in OP, checked in this order:
  - 0xFE RGB: 3 arg bytes r,g,b; a = pa.
  - 0xFF RGBA: 4 arg bytes r,g,b,a.
  - 2'b00 INDEX: pixel = index[in_data[5:0]]; no args.
  - 2'b01 DIFF: r = pr + in_data[5:4] − 2, g = pg + in_data[3:2] − 2, b = pb + in_data[1:0] − 2.
  - 2'b10 LUMA: 1 arg byte d. dg = in_data[5:0] − 32; g = pg + dg; r = pr + dg + d[7:4] − 8; b = pb + dg + d[3:0] − 8.
  - 2'b11 RUN (not 0xFE/0xFF): emit prev pixel (in_data[5:0] + 1) times, i.e. 1..62.
- All channel arithmetic is mod 256 (8-bit wrap). DIFF/LUMA/RUN/RGB keep a = pa.
- FSM states:
  - OP: accepts an opcode byte. Single-byte ops produce a pixel directly. RGB/RGBA/LUMA go to ARG. RUN with count > 1 goes to RUN.
  - ARG: accepts arg bytes. The final arg byte produces a pixel and returns to OP.
  - RUN: no input accepted. Each output slot re-emits prev. Leaves to OP when run_left reaches 0.
- Every emitted pixel, including each run pixel and each INDEX pixel, updates prev and writes index[(r·3 + g·5 + b·7 + a·11) mod 64].
- Reset mid-chunk discards partial args, any run in progress and any pending output pixel.

## Timing
- in_ready = !rst && state != RUN && (!out_valid || out_ready).
- One byte per cycle max. Output is registered: the byte completing a pixel, accepted on edge N, gives out_valid = 1 at N+1 with the pixel.
- Back-to-back single-byte ops with out_ready held high: 1 pixel/cycle.
- RUN of n: pixels at N+1 .. N+n on consecutive cycles while out_ready = 1; in_ready low until the cycle of the last run pixel.
- out_* are held stable while out_valid && !out_ready; no byte is accepted during that time.
- INDEX read sees an index write made by the immediately preceding pixel (write-then-read bypass required).
- in_valid low in mid-chunk: state is held, no timeout.

## Configuration
- QOI_DECODER_PXCOUNT_EN defined: adds port px_count[31:0], incremented on each out_valid && out_ready, cleared by rst, wraps at 2^32.
- QOI_DECODER_PXCOUNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset, then DIFF 0x40 → pixel (FE,FE,FE,FF), showing the wrap from prev (0,0,0,FF).
- RGB FE 10 20 30, then INDEX 0x15 → (10,20,30,FF) twice; hash 3349 mod 64 = 21.
- Reset, then LUMA A0 97 → (01,00,FF,FF). Follow with DIFF 0x7F → (02,01,00,FF).
- RGBA FF 01 02 03 80, then RUN 0xC2 → 4 pixels (01,02,03,80); in_ready low for the 2 cycles after the run byte.
- Backpressure: out_ready toggled randomly over a 100-byte mixed stream → output matches the reference model, no byte is dropped and out_* are stable while stalled. With the macro, px_count equals the pixel total.
- Assert rst during the arguments of RGBA FF 11 22, then send RUN 0xC0 → exactly one pixel (00,00,00,FF); INDEX 0x00 → (00,00,00,00).

Source files
------------

// File: rtl/qoi_decoder.sv
// rtl/qoi_decoder.sv - streaming QOI chunk decoder: one chunk byte in, one RGBA pixel out per cycle
// Define QOI_DECODER_PXCOUNT_EN to add the px_count consumed-pixel counter port.

module qoi_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic [7:0] out_a,
  output logic       out_valid,
  input  logic       out_ready
`ifdef QOI_DECODER_PXCOUNT_EN
  ,
  output logic [31:0] px_count
`endif
);

  typedef enum logic [1:0] {S_OP, S_ARG, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_pr, r_pg, r_pb, r_pa;
  logic [31:0] r_index [64];
  logic [1:0]  r_argcnt, w_argcnt_nxt;
  logic [7:0]  r_opc, w_opc_nxt;
  logic [7:0]  r_b0, r_b1, r_b2;
  logic [5:0]  r_run_left, w_run_left_nxt;

  logic        w_slot_free;
  logic        w_in_fire;
  logic        w_emit;
  logic        w_last_arg;
  logic [7:0]  w_px_r, w_px_g, w_px_b, w_px_a;
  logic [5:0]  w_hash;
  logic [31:0] w_idx;
  logic [7:0]  w_luma_dg;

  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = !rst && (r_state != S_RUN) && w_slot_free;
  assign w_in_fire   = in_valid && in_ready;
  // Index is a flop array written on the emitting edge, so the next cycle's read already sees it.
  assign w_idx       = r_index[in_data[5:0]];
  assign w_luma_dg   = {2'b00, r_opc[5:0]} - 8'd32;
  assign w_last_arg  = ((r_opc == 8'hFE) && (r_argcnt == 2'd2)) ||
                       ((r_opc == 8'hFF) && (r_argcnt == 2'd3)) ||
                       (r_opc[7:6] == 2'b10);
  assign w_hash      = w_px_r[5:0] * 6'd3 + w_px_g[5:0] * 6'd5 +
                       w_px_b[5:0] * 6'd7 + w_px_a[5:0] * 6'd11;

  always_comb begin
    w_state_nxt    = r_state;
    w_argcnt_nxt   = r_argcnt;
    w_opc_nxt      = r_opc;
    w_run_left_nxt = r_run_left;
    w_emit         = 1'b0;
    w_px_r         = r_pr;
    w_px_g         = r_pg;
    w_px_b         = r_pb;
    w_px_a         = r_pa;
    case (r_state)
      S_OP: begin
        if (w_in_fire) begin
          if ((in_data == 8'hFE) || (in_data == 8'hFF)) begin
            w_state_nxt  = S_ARG;
            w_opc_nxt    = in_data;
            w_argcnt_nxt = 2'd0;
          end else begin
            case (in_data[7:6])
              2'b00: begin
                w_emit = 1'b1;
                w_px_r = w_idx[31:24];
                w_px_g = w_idx[23:16];
                w_px_b = w_idx[15:8];
                w_px_a = w_idx[7:0];
              end
              2'b01: begin
                w_emit = 1'b1;
                w_px_r = r_pr + {6'd0, in_data[5:4]} - 8'd2;
                w_px_g = r_pg + {6'd0, in_data[3:2]} - 8'd2;
                w_px_b = r_pb + {6'd0, in_data[1:0]} - 8'd2;
              end
              2'b10: begin
                w_state_nxt  = S_ARG;
                w_opc_nxt    = in_data;
                w_argcnt_nxt = 2'd0;
              end
              default: begin
                // First run pixel goes out now; the rest come from S_RUN.
                w_emit = 1'b1;
                if (in_data[5:0] != 6'd0) begin
                  w_state_nxt    = S_RUN;
                  w_run_left_nxt = in_data[5:0];
                end
              end
            endcase
          end
        end
      end
      S_ARG: begin
        if (w_in_fire) begin
          if (w_last_arg) begin
            w_emit      = 1'b1;
            w_state_nxt = S_OP;
            if (r_opc[7:6] == 2'b10) begin
              w_px_r = r_pr + w_luma_dg + {4'd0, in_data[7:4]} - 8'd8;
              w_px_g = r_pg + w_luma_dg;
              w_px_b = r_pb + w_luma_dg + {4'd0, in_data[3:0]} - 8'd8;
            end else if (r_opc == 8'hFE) begin
              w_px_r = r_b0;
              w_px_g = r_b1;
              w_px_b = in_data;
            end else begin
              w_px_r = r_b0;
              w_px_g = r_b1;
              w_px_b = r_b2;
              w_px_a = in_data;
            end
          end else begin
            w_argcnt_nxt = r_argcnt + 2'd1;
          end
        end
      end
      S_RUN: begin
        if (w_slot_free) begin
          w_emit         = 1'b1;
          w_run_left_nxt = r_run_left - 6'd1;
          if (r_run_left == 6'd1) begin
            w_state_nxt = S_OP;
          end
        end
      end
      default: w_state_nxt = S_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OP;
      r_argcnt   <= 2'd0;
      r_opc      <= 8'd0;
      r_run_left <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_argcnt   <= w_argcnt_nxt;
      r_opc      <= w_opc_nxt;
      r_run_left <= w_run_left_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b0 <= 8'd0;
      r_b1 <= 8'd0;
      r_b2 <= 8'd0;
    end else if ((r_state == S_ARG) && w_in_fire) begin
      case (r_argcnt)
        2'd0:    r_b0 <= in_data;
        2'd1:    r_b1 <= in_data;
        2'd2:    r_b2 <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr      <= 8'd0;
      r_pg      <= 8'd0;
      r_pb      <= 8'd0;
      r_pa      <= 8'd255;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
      out_a     <= 8'd0;
      out_valid <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        r_index[i] <= 32'd0;
      end
    end else if (w_emit) begin
      r_pr            <= w_px_r;
      r_pg            <= w_px_g;
      r_pb            <= w_px_b;
      r_pa            <= w_px_a;
      out_r           <= w_px_r;
      out_g           <= w_px_g;
      out_b           <= w_px_b;
      out_a           <= w_px_a;
      out_valid       <= 1'b1;
      r_index[w_hash] <= {w_px_r, w_px_g, w_px_b, w_px_a};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef QOI_DECODER_PXCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      px_count <= 32'd0;
    end else if (out_valid && out_ready) begin
      px_count <= px_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qoi_decoder.sv
// tb/tb_qoi_decoder.sv - self-checking bench for qoi_decoder
// Table-driven chunk vectors, handshake timing sequences and a backpressured random stream.

module tb_qoi_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_r, out_g, out_b, out_a;
  logic       out_valid;
  logic       out_ready = 1'b1;
`ifdef QOI_DECODER_PXCOUNT_EN
  logic [31:0] px_count;
`endif

  qoi_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_r    (out_r),
    .out_g    (out_g),
    .out_b    (out_b),
    .out_a    (out_a),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef QOI_DECODER_PXCOUNT_EN
    ,
    .px_count (px_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic bp_en = 1'b0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic [7:0]  byt[$];
  logic        hold_pending = 1'b0;
  logic [31:0] held;

  typedef struct {
    string       name;
    logic        do_rst;
    int          nb;
    logic [47:0] bytes;
    int          npx;
    logic [31:0] px;
  } vec_t;

  vec_t vecs[10];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Collects consumed pixels and checks that a stalled output holds still.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check32("stall_hold", {out_valid, out_r, out_g, out_b, out_a}, {1'b1, held});
      end
      if (out_valid && !out_ready) begin
        check32("stall_in_ready", {31'd0, in_ready}, 32'd0);
        hold_pending = 1'b1;
        held = {out_r, out_g, out_b, out_a};
      end else begin
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) got.push_back({out_r, out_g, out_b, out_a});
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_out_px", {out_r, out_g, out_b, out_a}, 32'd0);
`ifdef QOI_DECODER_PXCOUNT_EN
    check32("rst_px_count", px_count, 32'd0);
`endif
    rst = 1'b0;
    got.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_data = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      if (t >= 200) begin
        check32("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_px(input int n, input int limit);
    int t;
    t = 0;
    while (got.size() < n && t < limit) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  logic [7:0]  mr, mg, mb, ma;
  logic [31:0] midx [64];

  task automatic model_emit(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic [7:0] a);
    int h;
    exp_q.push_back({r, g, b, a});
    mr = r; mg = g; mb = b; ma = a;
    h = (int'(r) * 3 + int'(g) * 5 + int'(b) * 7 + int'(a) * 11) % 64;
    midx[h] = {r, g, b, a};
  endtask

  task automatic gen_stream;
    logic [7:0] r, g, b, a, d, vg;
    logic [1:0] dr, dgg, db;
    logic [5:0] v6;
    logic [31:0] p;
    int op;
    mr = 8'd0; mg = 8'd0; mb = 8'd0; ma = 8'd255;
    for (int i = 0; i < 64; i++) midx[i] = 32'd0;
    byt.delete();
    exp_q.delete();
    while (byt.size() < 100) begin
      op = $urandom_range(0, 5);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); a = 8'($urandom);
      case (op)
        0: begin
          byt.push_back(8'hFE); byt.push_back(r); byt.push_back(g); byt.push_back(b);
          model_emit(r, g, b, ma);
        end
        1: begin
          byt.push_back(8'hFF); byt.push_back(r); byt.push_back(g); byt.push_back(b); byt.push_back(a);
          model_emit(r, g, b, a);
        end
        2: begin
          v6 = 6'($urandom_range(0, 63));
          byt.push_back({2'b00, v6});
          p = midx[v6];
          model_emit(p[31:24], p[23:16], p[15:8], p[7:0]);
        end
        3: begin
          dr = 2'($urandom); dgg = 2'($urandom); db = 2'($urandom);
          byt.push_back({2'b01, dr, dgg, db});
          model_emit(mr + {6'd0, dr} - 8'd2, mg + {6'd0, dgg} - 8'd2, mb + {6'd0, db} - 8'd2, ma);
        end
        4: begin
          v6 = 6'($urandom_range(0, 63));
          d = 8'($urandom);
          vg = {2'b00, v6} - 8'd32;
          byt.push_back({2'b10, v6}); byt.push_back(d);
          model_emit(mr + vg + {4'd0, d[7:4]} - 8'd8, mg + vg, mb + vg + {4'd0, d[3:0]} - 8'd8, ma);
        end
        default: begin
          v6 = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 61)) : 6'($urandom_range(0, 3));
          byt.push_back({2'b11, v6});
          for (int k = 0; k <= int'(v6); k++) model_emit(mr, mg, mb, ma);
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;

    vecs[0] = '{"diff_wrap",    1'b1, 1, {8'h40, 40'd0},                     1,  32'hFEFEFEFF};
    vecs[1] = '{"rgb_index",    1'b0, 5, {40'hFE10203015, 8'd0},             2,  32'h102030FF};
    vecs[2] = '{"luma",         1'b1, 2, {16'hA097, 32'd0},                  1,  32'h0100FFFF};
    vecs[3] = '{"diff_max",     1'b0, 1, {8'h7F, 40'd0},                     1,  32'h020100FF};
    vecs[4] = '{"rgba_run",     1'b0, 6, 48'hFF01020380C2,                   4,  32'h01020380};
    vecs[5] = '{"rgba_partial", 1'b0, 3, {24'hFF1122, 24'd0},                0,  32'h00000000};
    vecs[6] = '{"rst_run1",     1'b1, 1, {8'hC0, 40'd0},                     1,  32'h000000FF};
    vecs[7] = '{"index_zero",   1'b0, 1, {8'h00, 40'd0},                     1,  32'h00000000};
    vecs[8] = '{"run62",        1'b1, 1, {8'hFD, 40'd0},                     62, 32'h000000FF};
    vecs[9] = '{"luma_max",     1'b1, 2, {16'hBFFF, 32'd0},                  1,  32'h261F26FF};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) do_reset();
      got.delete();
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].bytes[47 - 8 * k -: 8]);
      wait_px(vecs[i].npx, 300);
      check32({vecs[i].name, "_count"}, got.size(), vecs[i].npx);
      for (int k = 0; k < got.size() && k < vecs[i].npx; k++) begin
        check32({vecs[i].name, "_px"}, got[k], vecs[i].px);
      end
    end

    // Registered output: pixel appears one edge after the completing byte.
    do_reset();
    in_data = 8'h40;
    in_valid = 1'b1;
    #1;
    check32("lat_in_ready", {31'd0, in_ready}, 32'd1);
    check32("lat_pre_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    check32("lat_out", {out_valid, out_r, out_g, out_b, out_a}, {1'b1, 32'hFEFEFEFF});

    // RUN of 3 holds in_ready low for exactly two cycles after the run byte.
    do_reset();
    for (int k = 0; k < 5; k++) send_byte(8'(40'hFF01020380 >> (32 - 8 * k)));
    wait_px(1, 100);
    in_data = 8'hC2;
    in_valid = 1'b1;
    #1;
    check32("run_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check32("run_in_ready", {31'd0, in_ready}, (k == 2) ? 32'd1 : 32'd0);
      check32("run_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      #1;
    end
    wait_px(4, 100);
    check32("run_total", got.size(), 32'd4);

    // Random mixed stream under random backpressure against the byte-level model.
    do_reset();
    gen_stream();
    bp_en = 1'b1;
    for (int k = 0; k < byt.size(); k++) send_byte(byt[k]);
    wait_px(exp_q.size(), 4000);
    bp_en = 1'b0;
    check32("bp_count", got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      check32("bp_px", got[k], exp_q[k]);
    end
`ifdef QOI_DECODER_PXCOUNT_EN
    check32("bp_px_count", px_count, exp_q.size());
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
